mips_cpu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit owning the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU over WIDTH clock cycles, one radix-2 step per cycle, and services MTHI/MTLO writes. It replaces the combinational product/quotient path in the CPU datapath. The CPU must stall MFHI/MFLO, and any new multiply/divide, while `busy` is high.

---
 rtl/mips_cpu_muldiv.sv | 165 ++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative radix-2 multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division on magnitudes. MTHI/MTLO are serviced while idle.
module mips_cpu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] orig_a;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;

  logic load, step, finish, last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    last       = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Operand conditioning: op[0] selects unsigned, op[1] selects divide.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  always_comb begin
    sign_a   = ~op[0] & a[WIDTH-1];
    sign_b   = ~op[0] & b[WIDTH-1];
    mag_a_in = sign_a ? -a : a;
    mag_b_in = sign_b ? -b : b;
  end

  // One iteration. The low accumulator holds the multiplier or dividend and shifts out as the result shifts in.
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, mag_b});
    diff    = shifted[WIDTH-1:0] - mag_b;
    if (is_div) begin
      nxt_hi = ge ? diff : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end

    prod = {nxt_hi, nxt_lo};
    if (neg_res) prod = -prod;

    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (mag_b == '0) begin
      res_hi = orig_a;
      res_lo = '1;
    end else begin
      res_hi = neg_rem ? -nxt_hi : nxt_hi;
      res_lo = neg_res ? -nxt_lo : nxt_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      mag_b   <= '0;
      orig_a  <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= finish;
      if (load) begin
        is_div  <= op[1];
        neg_res <= sign_a ^ sign_b;
        neg_rem <= sign_a;
        mag_b   <= mag_b_in;
        orig_a  <= a;
        acc_hi  <= '0;
        acc_lo  <= mag_a_in;
        cnt     <= '0;
      end
      if (step) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && !start) begin
        if (write_hi) hi <= write_data;
        if (write_lo) lo <= write_data;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: a 32-bit instance and an 8-bit instance.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, write_hi, write_lo;
  logic [1:0]  op;
  logic [31:0] a, b, write_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8, abort8, write_hi8, write_lo8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, write_data8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  always #5 clk = ~clk;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_cpu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .abort(abort8), .write_hi(write_hi8), .write_lo(write_lo8), .write_data(write_data8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation; samples a fixed window starting one step after the accept edge.
  task automatic do_op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int busy_cycles, output int done_pulses, output int done_at);
    tick();
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    busy_cycles = 0; done_pulses = 0; done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_at < 0) done_at = k;
      end
      tick();
    end
  endtask

  task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int busy_cycles, output int done_at);
    tick();
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    tick();
    start8 = 1'b0;
    busy_cycles = 0; done_at = -1;
    for (int k = 0; k < 14; k++) begin
      if (busy8) busy_cycles++;
      if (done8 && done_at < 0) done_at = k;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_flags: busy,done=%b expected 00", {busy, done});
    end
    tests_run++;
    if ({hi, lo} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    int bc, dp, da;
    do_op32(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dp, da);
    tests_run++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      tests_failed++;
      $display("FAIL multu_max: hi=%h lo=%h expected fffffffe/00000001", hi, lo);
    end
    tests_run++;
    if (bc !== 32) begin
      tests_failed++;
      $display("FAIL multu_busy_cycles: got %0d expected 32", bc);
    end
    tests_run++;
    if (dp !== 1) begin
      tests_failed++;
      $display("FAIL multu_done_pulses: got %0d expected 1", dp);
    end
    tests_run++;
    if (da !== 32) begin
      tests_failed++;
      $display("FAIL multu_latency: done at %0d expected 32", da);
    end
  endtask

  task automatic test_mult_div();
    int bc, dp, da;
    do_op32(MULT, 32'hFFFFFFFD, 32'd5, bc, dp, da);
    tests_run++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      tests_failed++;
      $display("FAIL mult_neg3x5: hi=%h lo=%h expected ffffffff/fffffff1", hi, lo);
    end
    do_op32(DIV, 32'hFFFFFFF9, 32'd2, bc, dp, da);
    tests_run++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      tests_failed++;
      $display("FAIL div_neg7_2: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
    do_op32(DIV, 32'h80000000, 32'hFFFFFFFF, bc, dp, da);
    tests_run++;
    if (hi !== 32'h0 || lo !== 32'h80000000) begin
      tests_failed++;
      $display("FAIL div_overflow: hi=%h lo=%h expected 00000000/80000000", hi, lo);
    end
    do_op32(DIV, 32'd7, 32'hFFFFFFFE, bc, dp, da);
    tests_run++;
    if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
      tests_failed++;
      $display("FAIL div_7_neg2: hi=%h lo=%h expected 00000001/fffffffd", hi, lo);
    end
    do_op32(DIV, 32'hFFFFFFFB, 32'd0, bc, dp, da);
    tests_run++;
    if (hi !== 32'hFFFFFFFB || lo !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL div_signed_by_zero: hi=%h lo=%h expected fffffffb/ffffffff", hi, lo);
    end
    do_op32(MULT, 32'h80000000, 32'h80000000, bc, dp, da);
    tests_run++;
    if (hi !== 32'h40000000 || lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL mult_minxmin: hi=%h lo=%h expected 40000000/00000000", hi, lo);
    end
  endtask

  task automatic test_divu();
    int bc, dp, da;
    do_op32(DIVU, 32'h1234, 32'd0, bc, dp, da);
    tests_run++;
    if (hi !== 32'h00001234 || lo !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL divu_by_zero: hi=%h lo=%h expected 00001234/ffffffff", hi, lo);
    end
    do_op32(DIVU, 32'd100, 32'd7, bc, dp, da);
    tests_run++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      tests_failed++;
      $display("FAIL divu_100_7: hi=%0d lo=%0d expected 2/14", hi, lo);
    end
    do_op32(DIVU, 32'hFFFFFFFF, 32'h80000000, bc, dp, da);
    tests_run++;
    if (hi !== 32'h7FFFFFFF || lo !== 32'd1) begin
      tests_failed++;
      $display("FAIL divu_large: hi=%h lo=%h expected 7fffffff/00000001", hi, lo);
    end
  endtask

  task automatic test_mt();
    int seen;
    tick();
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h11223344;
    tick();
    write_hi = 1'b0; write_lo = 1'b0;
    tests_run++;
    if (hi !== 32'h11223344 || lo !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL mt_both: hi=%h lo=%h expected 11223344/11223344", hi, lo);
    end
    write_hi = 1'b1; write_data = 32'hA5A5A5A5;
    tick();
    write_hi = 1'b0;
    tests_run++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL mthi: hi=%h lo=%h expected a5a5a5a5/11223344", hi, lo);
    end
    write_lo = 1'b1; write_data = 32'h5A5A5A5A;
    tick();
    write_lo = 1'b0;
    tests_run++;
    if (lo !== 32'h5A5A5A5A || hi !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("FAIL mtlo: hi=%h lo=%h expected a5a5a5a5/5a5a5a5a", hi, lo);
    end
    // Start together with MTHI/MTLO, then keep the strobes up during RUN.
    start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    tests_run++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mt_with_start: hi=%h lo=%h busy=%b expected a5a5a5a5/5a5a5a5a/1", hi, lo, busy);
    end
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (k == 20) begin
        write_hi = 1'b0; write_lo = 1'b0;
      end
      if (done) seen = 1;
      else tick();
    end
    write_hi = 1'b0; write_lo = 1'b0;
    tests_run++;
    if (seen == 0 || hi !== 32'd0 || lo !== 32'd6) begin
      tests_failed++;
      $display("FAIL mt_during_run: done_seen=%0d hi=%h lo=%h expected 1/0/6", seen, hi, lo);
    end
    tick();
  endtask

  task automatic test_busy_start();
    int dp;
    tick();
    start = 1'b1; op = MULTU; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0;
    dp = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 3) begin
        start = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
      end
      if (k == 8) start = 1'b0;
      if (done) dp++;
      tick();
    end
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      tests_failed++;
      $display("FAIL start_while_busy_result: hi=%h lo=%h expected 0/42", hi, lo);
    end
    tests_run++;
    if (dp !== 1) begin
      tests_failed++;
      $display("FAIL start_while_busy_done: got %0d pulses expected 1", dp);
    end
  endtask

  task automatic test_abort();
    int dp;
    tick();
    write_hi = 1'b1; write_data = 32'h0BADF00D;
    tick();
    write_hi = 1'b0; write_lo = 1'b1; write_data = 32'h600DCAFE;
    tick();
    write_lo = 1'b0;
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: busy=%b expected 0", busy);
    end
    dp = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dp++;
      tick();
    end
    tests_run++;
    if (dp !== 0) begin
      tests_failed++;
      $display("FAIL abort_done: got %0d pulses expected 0", dp);
    end
    tests_run++;
    if (hi !== 32'h0BADF00D || lo !== 32'h600DCAFE) begin
      tests_failed++;
      $display("FAIL abort_hilo: hi=%h lo=%h expected 0badf00d/600dcafe", hi, lo);
    end
  endtask

  task automatic test_reset_midrun();
    int dp;
    tick();
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_midrun: busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
    end
    dp = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dp++;
      tick();
    end
    tests_run++;
    if (dp !== 0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_midrun_discard: pulses=%0d lo=%h expected 0/0", dp, lo);
    end
  endtask

  task automatic test_w8();
    int bc, da;
    do_op8(MULT, 8'h80, 8'h80, bc, da);
    tests_run++;
    if (hi8 !== 8'h40 || lo8 !== 8'h00) begin
      tests_failed++;
      $display("FAIL w8_mult: hi=%h lo=%h expected 40/00", hi8, lo8);
    end
    tests_run++;
    if (bc !== 8 || da !== 8) begin
      tests_failed++;
      $display("FAIL w8_timing: busy=%0d done_at=%0d expected 8/8", bc, da);
    end
    do_op8(DIV, 8'h80, 8'h03, bc, da);
    tests_run++;
    if (hi8 !== 8'hFE || lo8 !== 8'hD6) begin
      tests_failed++;
      $display("FAIL w8_div: hi=%h lo=%h expected fe/d6", hi8, lo8);
    end
    do_op8(DIV, 8'h80, 8'hFF, bc, da);
    tests_run++;
    if (hi8 !== 8'h00 || lo8 !== 8'h80) begin
      tests_failed++;
      $display("FAIL w8_div_overflow: hi=%h lo=%h expected 00/80", hi8, lo8);
    end
  endtask

  task automatic test_back_to_back();
    int seen, da;
    tick();
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (done) seen = 1;
      else tick();
    end
    tests_run++;
    if (seen == 0 || hi !== 32'd2 || lo !== 32'd14) begin
      tests_failed++;
      $display("FAIL b2b_first: done_seen=%0d hi=%0d lo=%0d expected 1/2/14", seen, hi, lo);
    end
    start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept: busy=%b expected 1", busy);
    end
    da = -1;
    for (int k = 0; k < 40 && da < 0; k++) begin
      if (done) da = k;
      else tick();
    end
    tests_run++;
    if (da !== 32 || hi !== 32'd0 || lo !== 32'd81) begin
      tests_failed++;
      $display("FAIL b2b_second: done_at=%0d hi=%0d lo=%0d expected 32/0/81", da, hi, lo);
    end
    tick();
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; write_data = '0;
    start8 = 1'b0; abort8 = 1'b0; write_hi8 = 1'b0; write_lo8 = 1'b0;
    op8 = 2'b00; a8 = '0; b8 = '0; write_data8 = '0;
    reset = 1'b1;

    test_reset();
    test_multu();
    test_mult_div();
    test_divu();
    test_mt();
    test_busy_start();
    test_abort();
    test_reset_midrun();
    test_w8();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
